// File: rtl/ex_stage_pkg.sv
// Shared widths, stall encoding, HI/LO function codes and divider state type
// used by the execute stage and its iterative divider.
package ex_stage_pkg;
    localparam int ID_TO_EX_WD  = 164;
    localparam int EX_TO_MEM_WD = 81;
    localparam int STALL_W      = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] neg_if(input logic en, input logic [31:0] v);
        return en ? (~v + 32'd1) : v;
    endfunction
endpackage

// File: rtl/ex_stage_div_iter.sv
// 32-step restoring divider on operand magnitudes; signs are re-applied to the
// final quotient/remainder, and a zero divisor yields all-ones / dividend.
module div_iter
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        start,
    input  logic        sign_op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        hold,
    output logic        busy,
    output logic        done,
    output logic [31:0] quo,
    output logic [31:0] rem
);
    div_state_t  state;
    logic [4:0]  cnt;
    logic [63:0] part_p0;
    logic [31:0] dvsr_p0;
    logic [31:0] dvnd_p0;
    logic        neg_q_p0;
    logic        neg_r_p0;
    logic [32:0] trial;
    logic [63:0] part_next;

    // Shift in the next dividend bit; keep the difference only if it did not borrow.
    assign trial     = part_p0[63:31] - {1'b0, dvsr_p0};
    assign part_next = trial[32] ? {part_p0[62:0], 1'b0}
                                 : {trial[31:0], part_p0[30:0], 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DIV_IDLE;
            cnt   <= 5'd0;
        end else if (flush) begin
            state <= DIV_IDLE;
            cnt   <= 5'd0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        state <= DIV_BUSY;
                        cnt   <= 5'd0;
                    end
                end
                DIV_BUSY: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        state <= DIV_DONE;
                end
                DIV_DONE: begin
                    if (!hold)
                        state <= DIV_IDLE;
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

    // ---- p0: datapath registers, loaded on start and stepped while busy
    always_ff @(posedge clk) begin
        if (state == DIV_IDLE && start) begin
            part_p0  <= {32'd0, neg_if(sign_op & opa[31], opa)};
            dvsr_p0  <= neg_if(sign_op & opb[31], opb);
            dvnd_p0  <= opa;
            neg_q_p0 <= sign_op & (opa[31] ^ opb[31]);
            neg_r_p0 <= sign_op & opa[31];
        end else if (state == DIV_BUSY) begin
            part_p0 <= part_next;
        end
    end

    assign busy = (state == DIV_BUSY);
    assign done = (state == DIV_DONE);
    assign quo  = (dvsr_p0 == 32'd0) ? 32'hFFFF_FFFF : neg_if(neg_q_p0, part_p0[31:0]);
    assign rem  = (dvsr_p0 == 32'd0) ? dvnd_p0 : neg_if(neg_r_p0, part_p0[63:32]);
endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: decode/execute register, ALU, data-SRAM request,
// result forwarding, and HI/LO with a single-cycle multiplier and iterative divider.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [STALL_W-1:0]      stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    output logic                    ex_we,
    output logic [4:0]              ex_waddr,
    output logic [31:0]             ex_wdata,
    output logic                    ex_ram_read,
    output logic                    stallreq_for_ex
);
    logic [ID_TO_EX_WD-1:0] id_ex_p0;
    logic [4:0]  mem_op;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rs_val;
    logic [31:0] rt_val;

    // ---- p0: decode/execute pipeline register; an all-zero word is a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            id_ex_p0 <= '0;
        else if (flush)
            id_ex_p0 <= '0;
        else if (stall[2] == STOP && stall[3] == NO_STOP)
            id_ex_p0 <= '0;
        else if (stall[2] == NO_STOP)
            id_ex_p0 <= id_to_ex_bus;
    end

    assign {mem_op, pc, inst, alu_op, sel_src1, sel_src2, ram_en, ram_wen,
            rf_we, rf_waddr, sel_rf_res, rs_val, rt_val} = id_ex_p0;

    logic [31:0]        src1;
    logic [31:0]        src2;
    logic signed [31:0] src1_s;
    logic signed [31:0] src2_s;
    logic [31:0]        sra_res;
    logic [31:0]        alu_res;

    assign src1 = ({32{sel_src1[0]}} & rs_val)
                | ({32{sel_src1[1]}} & pc)
                | ({32{sel_src1[2]}} & {27'd0, inst[10:6]});
    assign src2 = ({32{sel_src2[0]}} & rt_val)
                | ({32{sel_src2[1]}} & sext16(inst[15:0]))
                | ({32{sel_src2[2]}} & 32'd8)
                | ({32{sel_src2[3]}} & {16'd0, inst[15:0]});
    assign src1_s  = src1;
    assign src2_s  = src2;
    assign sra_res = src2_s >>> src1[4:0];

    assign alu_res = ({32{alu_op[11]}} & (src1 + src2))
                   | ({32{alu_op[10]}} & (src1 - src2))
                   | ({32{alu_op[9]}}  & {31'd0, src1_s < src2_s})
                   | ({32{alu_op[8]}}  & {31'd0, src1 < src2})
                   | ({32{alu_op[7]}}  & (src1 & src2))
                   | ({32{alu_op[6]}}  & ~(src1 | src2))
                   | ({32{alu_op[5]}}  & (src1 | src2))
                   | ({32{alu_op[4]}}  & (src1 ^ src2))
                   | ({32{alu_op[3]}}  & (src2 << src1[4:0]))
                   | ({32{alu_op[2]}}  & (src2 >> src1[4:0]))
                   | ({32{alu_op[1]}}  & sra_res)
                   | ({32{alu_op[0]}}  & {inst[15:0], 16'd0});

    // Store byte lanes follow the low address bits; the write data is replicated.
    always_comb begin
        data_sram_wen   = 4'b0000;
        data_sram_wdata = rt_val;
        if (ram_wen[0]) begin
            data_sram_wen = 4'b1111;
        end else if (ram_wen[1]) begin
            data_sram_wen   = alu_res[1] ? 4'b1100 : 4'b0011;
            data_sram_wdata = {2{rt_val[15:0]}};
        end else if (ram_wen[2]) begin
            data_sram_wen   = 4'b0001 << alu_res[1:0];
            data_sram_wdata = {4{rt_val[7:0]}};
        end
    end

    logic       is_special;
    logic [5:0] funct;
    logic       is_mfhi, is_mflo, is_mthi, is_mtlo, is_mult, is_div;
    logic       mult_signed, div_signed;

    assign is_special  = (inst[31:26] == 6'd0);
    assign funct       = inst[5:0];
    assign is_mfhi     = is_special && funct == FN_MFHI;
    assign is_mflo     = is_special && funct == FN_MFLO;
    assign is_mthi     = is_special && funct == FN_MTHI;
    assign is_mtlo     = is_special && funct == FN_MTLO;
    assign is_mult     = is_special && (funct == FN_MULT || funct == FN_MULTU);
    assign is_div      = is_special && (funct == FN_DIV || funct == FN_DIVU);
    assign mult_signed = (funct == FN_MULT);
    assign div_signed  = (funct == FN_DIV);

    logic signed [63:0] mul_a;
    logic signed [63:0] mul_b;
    logic signed [63:0] product;
    logic        div_busy, div_done;
    logic [31:0] div_quo, div_rem;
    logic [31:0] hi_reg, lo_reg;

    assign mul_a   = {{32{mult_signed & rs_val[31]}}, rs_val};
    assign mul_b   = {{32{mult_signed & rt_val[31]}}, rt_val};
    assign product = mul_a * mul_b;

    div_iter u_div (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .start   (is_div),
        .sign_op (div_signed),
        .opa     (rs_val),
        .opb     (rt_val),
        .hold    (stall[3] == STOP),
        .busy    (div_busy),
        .done    (div_done),
        .quo     (div_quo),
        .rem     (div_rem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_reg <= 32'd0;
            lo_reg <= 32'd0;
        end else if (div_done) begin
            hi_reg <= div_rem;
            lo_reg <= div_quo;
        end else if (stall[3] == NO_STOP) begin
            if (is_mult)
                {hi_reg, lo_reg} <= product;
            else if (is_mthi)
                hi_reg <= rs_val;
            else if (is_mtlo)
                lo_reg <= rs_val;
        end
    end

    logic [31:0] ex_result;
    logic        we_eff;
    logic [4:0]  waddr_eff;

    assign ex_result = is_mfhi ? hi_reg : (is_mflo ? lo_reg : alu_res);
    assign we_eff    = rf_we | is_mfhi | is_mflo;
    assign waddr_eff = (is_mfhi | is_mflo) ? inst[15:11] : rf_waddr;

    assign ex_to_mem_bus   = {mem_op, pc, ram_en, ram_wen, sel_rf_res, we_eff, waddr_eff, ex_result};
    assign data_sram_en    = ram_en;
    assign data_sram_addr  = alu_res;
    assign ex_we           = we_eff;
    assign ex_waddr        = waddr_eff;
    assign ex_wdata        = ex_result;
    assign ex_ram_read     = |mem_op;
    assign stallreq_for_ex = is_div & ~div_done;

    logic unused_bits;
    assign unused_bits = ^{stall[5:4], stall[1:0], inst[25:16], ram_wen[3], div_busy};
endmodule
